comb2_adder_reg: RTL and testbench
==================================

Name: comb2_adder_reg

Overview:
- Registered WIDTH-bit adder/subtractor that produces a WIDTH-bit result O and a carry-out, Carry.
- With default parameters, A=4'b1111 and B=4'b1111 give O=4'b1110 and Carry=1.
- Used as a small arithmetic leaf in datapaths. It has one clock; its outputs are registered and carry a valid flag.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands and control are valid this cycle.
- sub  input  1  0 = add (A+B), 1 = subtract (A-B).
- cin  input  1  carry-in for add; inverted borrow-in for subtract.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- O  output  WIDTH  registered result.
- Carry  output  1  registered carry-out (add) or not-borrow (subtract).
- out_valid  output  1  O and Carry hold a new result this cycle.

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on rising clk edge; clk, rst_n naming fixed).
- Reset: while rst_n=0 at a rising edge, O=0, Carry=0, out_valid=0. Inputs are ignored that cycle.
- Arithmetic uses a WIDTH+1-bit sum, S.
  - Add: S = {0,A} + {0,B} + cin.
  - Subtract: S = {0,A} + {0,~B} + cin, so cin=1 gives plain A-B.
  - O = S[WIDTH-1:0] and Carry = S[WIDTH].
  - Subtract with cin=1: Carry=1 when A>=B, else 0.
- Latency is 1 cycle. If in_valid=1 at edge N and rst_n=1, then after edge N: O and Carry hold the result of the inputs sampled at N, and out_valid=1.
- If in_valid=0 at an edge: out_valid goes 0, and O and Carry hold their previous values.
- No backpressure; a new operation can be accepted every cycle. Back-to-back valid inputs give back-to-back results.
- Wrap-around: the result is modulo 2^WIDTH and the excess appears only on Carry. Examples: 15+15 → O=14, Carry=1; 15+0+cin=1 → O=0, Carry=1.
- Reset mid-stream: reset takes priority over in_valid. An operation presented in the same cycle as reset is discarded, and out_valid=0 on the following cycle.
- No X propagation: O, Carry and out_valid are always driven from registers.

Optional Feature:
- Macro COMB2_FLAGS_EN.
- When defined, two extra registered outputs are added, each 1 bit wide. Both update under the same in_valid/hold rules as O and are cleared to 0 by reset.
  - zero: 1 when O == 0.
  - ovf: signed two's-complement overflow. Add: A and B have the same sign and O's sign differs. Subtract: A and B have different signs and O's sign differs from A's.
- When not defined, neither port exists and no flag logic is generated. Behaviour of O, Carry and out_valid is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=5, B=3 → O=0, Carry=0, out_valid=0 throughout. Release reset → first result appears 1 cycle after the next valid input.
- Max add: sub=0, cin=0, A=4'b1111, B=4'b1111, in_valid=1 → next cycle O=4'b1110, Carry=1, out_valid=1.
- Carry-in wrap: sub=0, cin=1, A=15, B=0 → O=0, Carry=1. With COMB2_FLAGS_EN: zero=1, ovf=0.
- Subtract with borrow: sub=1, cin=1.
  - A=3, B=5 → O=4'b1110, Carry=0.
  - Then A=9, B=4 → O=5, Carry=1.
  - Both on consecutive cycles, with out_valid high on both.
- Hold: valid A=2, B=2 (O=4), then in_valid=0 with A=7, B=7 → O stays 4, Carry stays 0, out_valid=0.
- Signed overflow (COMB2_FLAGS_EN): sub=0, A=7, B=1 → O=8, Carry=0, ovf=1. Then sub=1, cin=1, A=8, B=1 → O=7, ovf=1.

Source files
------------

// File: rtl/comb2_adder_reg.sv
// Registered WIDTH-bit adder/subtractor with carry-out and a valid flag.
// Define COMB2_FLAGS_EN to add registered zero and signed-overflow flags.
module comb2_adder_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] O,
    output logic             Carry,
`ifdef COMB2_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] o_q;
    logic             carry_q;
    logic             valid_q;

    // Subtraction is A + ~B + cin, so cin doubles as the inverted borrow-in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        b_op  = B;
        sum_d = '0;
        if (sub) begin
            b_op = ~B;
        end
        sum_d = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register updates from pre-edge values.
        if (!rst_n) begin
            o_q     <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                o_q     <= sum_d[WIDTH-1:0];
                carry_q <= sum_d[WIDTH];
            end
        end
    end

    assign O         = o_q;
    assign Carry     = carry_q;
    assign out_valid = valid_q;

`ifdef COMB2_FLAGS_EN
    logic zero_d;
    logic ovf_d;
    logic zero_q;
    logic ovf_q;

    // Operands of equal sign (B already inverted for subtract) whose sum flips sign overflow.
    always_comb begin
        zero_d = (sum_d[WIDTH-1:0] == '0);
        ovf_d  = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum_d[WIDTH-1] != A[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (in_valid) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_comb2_adder_reg.sv
// Self-checking bench for comb2_adder_reg: directed literal cases plus random
// stimulus compared every cycle against an arithmetic reference model.
module tb_comb2_adder_reg;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] O;
    logic             Carry;
    logic             out_valid;
`ifdef COMB2_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    int tests  = 0;
    int failed = 0;

    int exp_o;
    int exp_c;
    int exp_v;
    int exp_z;
    int exp_ovf;
    bit started = 1'b0;

    comb2_adder_reg #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .sub      (sub),
        .cin      (cin),
        .A        (A),
        .B        (B),
        .O        (O),
        .Carry    (Carry),
`ifdef COMB2_FLAGS_EN
        .zero     (zero),
        .ovf      (ovf),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the sampled operands.
    always @(posedge clk) begin
        int s;
        int sa;
        int sb;
        int sv;
        started = 1'b1;
        if (rst_n !== 1'b1) begin
            exp_o = 0; exp_c = 0; exp_v = 0; exp_z = 0; exp_ovf = 0;
        end else begin
            exp_v = in_valid;
            if (in_valid) begin
                s  = sub ? (int'(A) - int'(B) - 1 + MODV + int'(cin)) : (int'(A) + int'(B) + int'(cin));
                sa = (int'(A) >= MODV / 2) ? int'(A) - MODV : int'(A);
                sb = (int'(B) >= MODV / 2) ? int'(B) - MODV : int'(B);
                sv = sub ? (sa - sb - 1 + int'(cin)) : (sa + sb + int'(cin));
                exp_o   = s % MODV;
                exp_c   = s / MODV;
                exp_z   = (exp_o == 0);
                exp_ovf = (sv < -(MODV / 2)) || (sv > MODV / 2 - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_O", int'(O), exp_o);
            check("model_Carry", int'(Carry), exp_c);
            check("model_out_valid", int'(out_valid), exp_v);
`ifdef COMB2_FLAGS_EN
            check("model_zero", int'(zero), exp_z);
            check("model_ovf", int'(ovf), exp_ovf);
`endif
        end
    end

    // Present inputs (caller is at a negedge), then advance to the next negedge.
    task automatic step(input logic r, input logic v, input logic s, input logic c,
                        input int a, input int b);
        rst_n    = r;
        in_valid = v;
        sub      = s;
        cin      = c;
        A        = WIDTH'(a);
        B        = WIDTH'(b);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; sub = 1'b0; cin = 1'b0; A = 4'd5; B = 4'd3;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 5, 3);
            check("reset_O", int'(O), 0);
            check("reset_Carry", int'(Carry), 0);
            check("reset_out_valid", int'(out_valid), 0);
        end

        step(1'b1, 1'b0, 1'b0, 1'b0, 5, 3);
        check("post_reset_idle_valid", int'(out_valid), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5, 3);
        check("first_result_O", int'(O), 8);
        check("first_result_valid", int'(out_valid), 1);

        step(1'b1, 1'b1, 1'b0, 1'b0, 15, 15);
        check("max_add_O", int'(O), 14);
        check("max_add_Carry", int'(Carry), 1);

        step(1'b1, 1'b1, 1'b0, 1'b1, 15, 0);
        check("cin_wrap_O", int'(O), 0);
        check("cin_wrap_Carry", int'(Carry), 1);
`ifdef COMB2_FLAGS_EN
        check("cin_wrap_zero", int'(zero), 1);
        check("cin_wrap_ovf", int'(ovf), 0);
`endif

        step(1'b1, 1'b1, 1'b1, 1'b1, 3, 5);
        check("sub_borrow_O", int'(O), 14);
        check("sub_borrow_Carry", int'(Carry), 0);
        check("sub_borrow_valid", int'(out_valid), 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 9, 4);
        check("sub_plain_O", int'(O), 5);
        check("sub_plain_Carry", int'(Carry), 1);
        check("sub_plain_valid", int'(out_valid), 1);

        step(1'b1, 1'b1, 1'b0, 1'b0, 2, 2);
        check("hold_load_O", int'(O), 4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 7, 7);
        check("hold_O", int'(O), 4);
        check("hold_Carry", int'(Carry), 0);
        check("hold_valid", int'(out_valid), 0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 7, 1);
        check("sovf_add_O", int'(O), 8);
        check("sovf_add_Carry", int'(Carry), 0);
`ifdef COMB2_FLAGS_EN
        check("sovf_add_ovf", int'(ovf), 1);
`endif
        step(1'b1, 1'b1, 1'b1, 1'b1, 8, 1);
        check("sovf_sub_O", int'(O), 7);
`ifdef COMB2_FLAGS_EN
        check("sovf_sub_ovf", int'(ovf), 1);
`endif

        step(1'b0, 1'b1, 1'b0, 1'b0, 6, 6);
        check("mid_reset_valid", int'(out_valid), 0);
        check("mid_reset_O", int'(O), 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
